// File: rtl/gtxe2_chnl_tx_oob.sv
// Transmit-side out-of-band sequencer: emits COMINIT/COMWAKE burst/gap patterns,
// otherwise passes ser_in through or holds the line in electrical idle.
module gtxe2_chnl_tx_oob #(
  parameter int BURST_LEN    = 160,
  parameter int WAKE_GAP_LEN = 160,
  parameter int INIT_GAP_LEN = 480,
  parameter int BURSTS_CNT   = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic TXCOMINIT,
  input  logic TXCOMWAKE,
  input  logic TXELECIDLE,
  input  logic ser_in,
  output logic TXP,
  output logic TXN,
  output logic TXCOMFINISH,
  output logic oob_busy
);

  localparam logic [1:0] READY = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [15:0] BURST_LEN_W  = 16'(BURST_LEN);
  localparam logic [15:0] WAKE_GAP_W   = 16'(WAKE_GAP_LEN);
  localparam logic [15:0] INIT_GAP_W   = 16'(INIT_GAP_LEN);
  localparam logic [15:0] BURSTS_CNT_W = 16'(BURSTS_CNT);

  logic [1:0]  state;
  logic [15:0] cyc_cnt;
  logic [15:0] burst_cnt;
  logic        is_init;
  logic [15:0] gap_len;
  logic        pass_p;
  logic        pass_n;

  assign gap_len = is_init ? INIT_GAP_W : WAKE_GAP_W;
  // Line value when no sequence owns the pair: idle forces both legs low.
  assign pass_p  = ~TXELECIDLE &  ser_in;
  assign pass_n  = ~TXELECIDLE & ~ser_in;

  // cyc_cnt holds the 1-based index of the cycle currently on TXP/TXN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= READY;
      cyc_cnt     <= '0;
      burst_cnt   <= '0;
      is_init     <= 1'b0;
      TXP         <= 1'b0;
      TXN         <= 1'b0;
      TXCOMFINISH <= 1'b0;
      oob_busy    <= 1'b0;
    end else begin
      TXCOMFINISH <= 1'b0;
      case (state)
        READY: begin
          if (TXCOMINIT || TXCOMWAKE) begin
            state     <= BURST;
            is_init   <= TXCOMINIT;
            cyc_cnt   <= 16'd1;
            burst_cnt <= '0;
            TXP       <= 1'b1;
            TXN       <= 1'b0;
            oob_busy  <= 1'b1;
          end else begin
            TXP <= pass_p;
            TXN <= pass_n;
          end
        end
        BURST: begin
          if (cyc_cnt == BURST_LEN_W) begin
            state     <= GAP;
            cyc_cnt   <= 16'd1;
            burst_cnt <= burst_cnt + 16'd1;
            TXP       <= 1'b0;
            TXN       <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            TXP     <= ~TXP;
            TXN     <= TXP;
          end
        end
        GAP: begin
          if (cyc_cnt == gap_len) begin
            if (burst_cnt < BURSTS_CNT_W) begin
              state   <= BURST;
              cyc_cnt <= 16'd1;
              TXP     <= 1'b1;
              TXN     <= 1'b0;
            end else begin
              state       <= READY;
              cyc_cnt     <= '0;
              burst_cnt   <= '0;
              oob_busy    <= 1'b0;
              TXCOMFINISH <= 1'b1;
              TXP         <= pass_p;
              TXN         <= pass_n;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: begin
          state    <= READY;
          cyc_cnt  <= '0;
          oob_busy <= 1'b0;
          TXP      <= 1'b0;
          TXN      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
// Directed + randomized bench; expected line state derived from sequence position arithmetic.
module tb_gtxe2_chnl_tx_oob;
  localparam int BL = 160, WG = 160, IG = 480, BC = 6;

  logic clk = 1'b0;
  logic reset_n, TXCOMINIT, TXCOMWAKE, TXELECIDLE, ser_in;
  logic TXP, TXN, TXCOMFINISH, oob_busy;

  int n_assert = 0, n_fail = 0;

  // reference model state
  bit m_active = 0, m_init = 0;
  int m_pos = 0, m_total = 0, m_fin_cnt = 0, m_bursts_seen = 0;
  logic e_txp, e_txn, e_fin, e_busy;

  gtxe2_chnl_tx_oob #(.BURST_LEN(BL), .WAKE_GAP_LEN(WG), .INIT_GAP_LEN(IG), .BURSTS_CNT(BC)) dut (
    .clk(clk), .reset_n(reset_n), .TXCOMINIT(TXCOMINIT), .TXCOMWAKE(TXCOMWAKE),
    .TXELECIDLE(TXELECIDLE), .ser_in(ser_in), .TXP(TXP), .TXN(TXN),
    .TXCOMFINISH(TXCOMFINISH), .oob_busy(oob_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b pos=%0d", tag, obs, exp, m_pos);
    end
  endtask

  // Advance one clock; model consumes the inputs sampled at that edge, then outputs are compared.
  task automatic step();
    logic r, ci, cw, ei, si;
    int per, m;
    r = reset_n; ci = TXCOMINIT; cw = TXCOMWAKE; ei = TXELECIDLE; si = ser_in;
    @(posedge clk);
    e_fin = 1'b0;
    if (!r) begin
      m_active = 0; e_txp = 0; e_txn = 0; e_busy = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == m_total) begin
        m_active = 0; e_fin = 1; e_busy = 0; m_fin_cnt++;
        e_txp = ~ei & si; e_txn = ~ei & ~si;
      end else begin
        per = BL + (m_init ? IG : WG);
        m = m_pos % per;
        e_busy = 1;
        if (m < BL) begin e_txp = (m % 2 == 0); e_txn = ~e_txp; end
        else begin e_txp = 0; e_txn = 0; end
        if (m == 0) m_bursts_seen++;
      end
    end else if (ci || cw) begin
      m_active = 1; m_init = ci; m_pos = 0; m_bursts_seen = 1;
      m_total = BC * (BL + (ci ? IG : WG));
      e_txp = 1; e_txn = 0; e_busy = 1;
    end else begin
      e_txp = ~ei & si; e_txn = ~ei & ~si; e_busy = 0;
    end
    #1;
    chk("txp", TXP, e_txp);
    chk("txn", TXN, e_txn);
    chk("finish", TXCOMFINISH, e_fin);
    chk("busy", oob_busy, e_busy);
  endtask

  // Run until the model's sequence ends, scrambling data/idle and injecting stray requests.
  task automatic run_seq(input int wake_at_pos);
    int guard = 0;
    while (m_active && guard < 5000) begin
      TXELECIDLE = 1'($urandom);
      ser_in     = 1'($urandom);
      TXCOMINIT  = ($urandom_range(0, 49) == 0);
      TXCOMWAKE  = (m_pos == wake_at_pos - 1) || ($urandom_range(0, 49) == 0);
      step();
      guard++;
    end
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL seq_timeout observed=%0d cycles expected=<5000", guard);
    end
    TXCOMINIT = 0; TXCOMWAKE = 0;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 0; TXCOMINIT = 1; TXCOMWAKE = 0; TXELECIDLE = 1; ser_in = 0;
    // reset with a pending COMINIT: it must be discarded
    repeat (3) step();
    TXCOMINIT = 0; reset_n = 1;
    repeat (3) step();

    // passthrough 1,0,1 then random data, then idle
    TXELECIDLE = 0;
    ser_in = 1; step(); ser_in = 0; step(); ser_in = 1; step();
    repeat (8) begin ser_in = 1'($urandom); step(); end
    TXELECIDLE = 1; repeat (3) begin ser_in = 1'($urandom); step(); end

    // COMINIT pulse
    TXCOMINIT = 1; step(); TXCOMINIT = 0;
    chk_int("init_total", m_total, 3840);
    m_fin_cnt = 0;
    run_seq(-10);
    chk_int("init_fin_cnt", m_fin_cnt, 1);
    chk_int("init_bursts", m_bursts_seen, BC);
    TXELECIDLE = 1; repeat (4) step();

    // COMWAKE pulse
    TXCOMWAKE = 1; step(); TXCOMWAKE = 0;
    chk_int("wake_total", m_total, 1920);
    m_fin_cnt = 0;
    run_seq(-10);
    chk_int("wake_fin_cnt", m_fin_cnt, 1);

    // new request in the finish cycle is accepted (WAKE back-to-back)
    TXCOMWAKE = 1; step(); TXCOMWAKE = 0;
    run_seq(-10);

    // both high -> INIT; COMWAKE pulsed during burst 3 is ignored
    TXCOMINIT = 1; TXCOMWAKE = 1; step(); TXCOMINIT = 0; TXCOMWAKE = 0;
    chk_int("arb_is_init", int'(m_init), 1);
    m_fin_cnt = 0;
    run_seq(2 * (BL + IG) + 20);
    chk_int("arb_fin_cnt", m_fin_cnt, 1);
    chk_int("arb_bursts", m_bursts_seen, BC);
    TXELECIDLE = 1; repeat (2) step();

    // reset on cycle 50 of burst 2
    TXCOMINIT = 1; step(); TXCOMINIT = 0;
    while (m_active && m_pos < (BL + IG) + 49) begin
      TXELECIDLE = 1'($urandom); ser_in = 1'($urandom); step();
    end
    reset_n = 0; step();
    reset_n = 1; TXELECIDLE = 1; repeat (5) step();
    TXCOMWAKE = 1; step(); TXCOMWAKE = 0;
    m_fin_cnt = 0;
    run_seq(-10);
    chk_int("post_rst_fin_cnt", m_fin_cnt, 1);
    chk_int("post_rst_bursts", m_bursts_seen, BC);

    // random requests interleaved with passthrough
    repeat (4) begin
      TXELECIDLE = 1'($urandom);
      repeat ($urandom_range(1, 6)) begin ser_in = 1'($urandom); step(); end
      TXCOMINIT = 1'($urandom); TXCOMWAKE = ~TXCOMINIT | 1'($urandom);
      step(); TXCOMINIT = 0; TXCOMWAKE = 0;
      run_seq(-10);
    end
    TXELECIDLE = 1; repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/gtxe2_chnl_tx_oob.md
GTXE2_CHNL_TX_OOB -- requirements
Module: gtxe2_chnl_tx_oob

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 160, meaning the clk cycles per burst.
REQ-002 The block SHALL have parameter WAKE_GAP_LEN, default 160, meaning the clk cycles per COMWAKE idle gap.
REQ-003 The block SHALL have parameter INIT_GAP_LEN, default 480, meaning the clk cycles per COMINIT idle gap.
REQ-004 The block SHALL have parameter BURSTS_CNT, default 6, meaning the bursts per sequence.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port TXCOMINIT, input, 1 bit: COMINIT request.
REQ-008 The block SHALL have port TXCOMWAKE, input, 1 bit: COMWAKE request.
REQ-009 The block SHALL have port TXELECIDLE, input, 1 bit: force electrical idle when no sequence runs.
REQ-010 The block SHALL have port ser_in, input, 1 bit: serial data bit for normal transmission.
REQ-011 The block SHALL have port TXP, output, 1 bit: positive line.
REQ-012 The block SHALL have port TXN, output, 1 bit: negative line.
REQ-013 The block SHALL have port TXCOMFINISH, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port oob_busy, output, 1 bit: high while a sequence runs.

Function
REQ-015 The block SHALL implement an FSM with states READY, BURST and GAP; sequence type (INIT/WAKE) is latched at start.
REQ-016 In READY, TXCOMINIT or TXCOMWAKE high at edge N SHALL move the FSM to BURST, and TXP/TXN SHALL show the first burst cycle from cycle N+1.
REQ-017 When TXCOMINIT and TXCOMWAKE are both high in READY, INIT SHALL win.
REQ-018 Requests while oob_busy=1 SHALL be ignored and not queued.
REQ-019 In BURST, TXP SHALL be 1 on the first burst cycle and toggle every cycle, with TXN=~TXP, for exactly BURST_LEN cycles.
REQ-020 After each burst, the FSM SHALL enter GAP with TXP=TXN=0 for exactly INIT_GAP_LEN (INIT) or WAKE_GAP_LEN (WAKE) cycles.
REQ-021 A burst counter SHALL increment at each BURST->GAP transition.
REQ-022 After a GAP, the FSM SHALL return to BURST if the count is < BURSTS_CNT, else go to READY.
REQ-023 The trailing gap after the last burst SHALL be present and of full length.
REQ-024 Total sequence length SHALL be BURSTS_CNT*(BURST_LEN+gap) cycles, e.g. 3840 for INIT and 1920 for WAKE at default parameters.
REQ-025 TXCOMFINISH SHALL be high for exactly one cycle, in the first cycle after the last gap cycle; oob_busy SHALL be 0 in that same cycle.
REQ-026 A new request sampled in the TXCOMFINISH cycle SHALL be accepted.
REQ-027 oob_busy SHALL be 1 from cycle N+1 through the last gap cycle.
REQ-028 In READY with TXELECIDLE=1, the block SHALL drive TXP=TXN=0.
REQ-029 In READY with TXELECIDLE=0, the block SHALL drive TXP=ser_in and TXN=~ser_in, registered with one cycle of latency.
REQ-030 During a sequence, the OOB pattern SHALL override TXELECIDLE and ser_in.
REQ-031 All outputs SHALL be registered.
REQ-032 Cycle and burst counters SHALL be 16 bits wide.
REQ-033 All length parameters SHALL be >= 1, and BURSTS_CNT SHALL be >= 1.

Reset
REQ-034 While reset_n=0 at a clock edge, the block SHALL go to READY, clear all counters, and drive TXP=0, TXN=0, TXCOMFINISH=0, oob_busy=0.
REQ-035 Reset mid-sequence SHALL abort immediately with no TXCOMFINISH; after release, any request SHALL start a fresh sequence from burst 1.
REQ-036 Requests sampled while reset_n=0 SHALL be discarded.

Verification
REQ-037 Reset check: hold reset_n=0 for 3 cycles with TXCOMINIT=1 -> TXP=TXN=0, oob_busy=0, TXCOMFINISH=0; no sequence starts on release unless TXCOMINIT is still high.
REQ-038 COMINIT at defaults: pulse TXCOMINIT at edge N -> 6 bursts of 160 toggling cycles, each followed by 480 cycles with TXP=TXN=0; TXCOMFINISH is high only at cycle N+3841; feeding TXP/TXN to the channel OOB detector raises its COMINIT detect and never its COMWAKE detect.
REQ-039 COMWAKE at defaults: gaps of 160 cycles; TXCOMFINISH at N+1921; the detector reports COMWAKE only.
REQ-040 Arbitration and busy: TXCOMINIT and TXCOMWAKE high together -> INIT timing; TXCOMWAKE pulsed at burst 3 -> ignored, exactly 6 bursts, one TXCOMFINISH.
REQ-041 Reset mid-sequence: assert reset_n=0 on cycle 50 of burst 2 -> next cycle TXP=TXN=0, oob_busy=0, no TXCOMFINISH; a later TXCOMWAKE produces a full 6-burst sequence.
REQ-042 Idle and passthrough: with TXELECIDLE=1 -> TXP=TXN=0; with TXELECIDLE=0 and ser_in=1,0,1 -> TXP=1,0,1 one cycle later and TXN its complement.
